// File: rtl/nes_debugger_mem_arbiter_pkg.sv
// Shared types for the NES/debugger memory arbiter: access direction encoding and arbiter states.
package nes_debugger_mem_arbiter_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    ISSUE,
    CAPTURE,
    DONE
  } arb_state_t;

endpackage

// File: rtl/nes_debugger_mem_arbiter_if.sv
// NES, debugger and memory-side signals of one arbiter instance.
// The master modport is the environment (NES master, debugger, memory read port); the slave is the arbiter.
interface nes_debugger_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  nes_en;
  logic                  nes_rw;
  logic [ADDR_WIDTH-1:0] nes_address;
  logic [DATA_WIDTH-1:0] nes_wr_data;
  logic [DATA_WIDTH-1:0] nes_rd_data;

  logic                  dbg_req;
  logic                  dbg_rw;
  logic [ADDR_WIDTH-1:0] dbg_address;
  logic [DATA_WIDTH-1:0] dbg_wr_data;
  logic                  dbg_ready;
  logic                  dbg_done;
  logic [DATA_WIDTH-1:0] dbg_rd_data;
  logic                  dbg_starved;

  logic                  mem_en;
  logic                  mem_wea;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output nes_en, nes_rw, nes_address, nes_wr_data,
    output dbg_req, dbg_rw, dbg_address, dbg_wr_data,
    output mem_rd_data,
    input  nes_rd_data, dbg_ready, dbg_done, dbg_rd_data, dbg_starved,
    input  mem_en, mem_wea, mem_address, mem_wr_data
  );

  modport slave (
    input  nes_en, nes_rw, nes_address, nes_wr_data,
    input  dbg_req, dbg_rw, dbg_address, dbg_wr_data,
    input  mem_rd_data,
    output nes_rd_data, dbg_ready, dbg_done, dbg_rd_data, dbg_starved,
    output mem_en, mem_wea, mem_address, mem_wr_data
  );
endinterface

// File: rtl/nes_debugger_mem_arbiter.sv
// Shares one single-port sync memory: NES access always passes through combinationally; one latched
// debugger request fills NES-idle cycles (done 4 cycles after req when idle). NES_DEBUGGER_ARB_STATS_EN adds o_conflict_count.
module nes_debugger_mem_arbiter
  import nes_debugger_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int WAIT_WIDTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  nes_debugger_mem_arbiter_if.slave      bus
`ifdef NES_DEBUGGER_ARB_STATS_EN
  ,
  output logic [15:0]                    o_conflict_count
`endif
);

  arb_state_t            state;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_data;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic                  ready_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] dbg_rd_q;
  logic                  nes_rd_pending;
  logic [DATA_WIDTH-1:0] nes_rd_q;
  logic                  blocked;

  assign blocked = bus.nes_en && ((state == PEND) || (state == ISSUE));

  // NES never waits: it owns the port whenever it asks, the debugger only gets ISSUE cycles it leaves idle.
  always_comb begin
    bus.mem_en      = 1'b0;
    bus.mem_wea     = 1'b0;
    bus.mem_address = '0;
    bus.mem_wr_data = '0;
    if (bus.nes_en) begin
      bus.mem_en      = 1'b1;
      bus.mem_wea     = ~bus.nes_rw;
      bus.mem_address = bus.nes_address;
      bus.mem_wr_data = bus.nes_wr_data;
    end else if (state == ISSUE) begin
      bus.mem_en      = 1'b1;
      bus.mem_wea     = (req_rw == RW_WRITE);
      bus.mem_address = req_address;
      bus.mem_wr_data = req_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      req_rw      <= RW_READ;
      req_address <= '0;
      req_data    <= '0;
      wait_cnt    <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      dbg_rd_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (blocked && !(&wait_cnt)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.dbg_req) begin
            req_rw      <= bus.dbg_rw;
            req_address <= bus.dbg_address;
            req_data    <= bus.dbg_wr_data;
            ready_q     <= 1'b0;
            state       <= PEND;
          end
        end
        PEND: begin
          if (!bus.nes_en) state <= ISSUE;
        end
        ISSUE: begin
          if (!bus.nes_en) state <= CAPTURE;
        end
        CAPTURE: begin
          // Memory read data belongs to the ISSUE access one cycle earlier.
          if (req_rw == RW_READ) dbg_rd_q <= bus.mem_rd_data;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          ready_q  <= 1'b1;
          wait_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      nes_rd_pending <= 1'b0;
      nes_rd_q       <= '0;
    end else begin
      nes_rd_pending <= bus.nes_en && (bus.nes_rw == RW_READ);
      if (nes_rd_pending) nes_rd_q <= bus.mem_rd_data;
    end
  end

  assign bus.nes_rd_data = nes_rd_pending ? bus.mem_rd_data : nes_rd_q;
  assign bus.dbg_ready   = ready_q;
  assign bus.dbg_done    = done_q;
  assign bus.dbg_rd_data = dbg_rd_q;
  assign bus.dbg_starved = &wait_cnt;

`ifdef NES_DEBUGGER_ARB_STATS_EN
  logic [15:0] conflict_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      conflict_q <= '0;
    end else if (blocked && !(&conflict_q)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign o_conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_nes_debugger_mem_arbiter.sv
// Randomized NES/debugger traffic with a queue scoreboard; expected timing derived from the NES-enable schedule.
module tb_nes_debugger_mem_arbiter;

  localparam int AW         = 16;
  localparam int DW         = 8;
  localparam int WW         = 3;
  localparam int WMAX       = (1 << WW) - 1;
  localparam int N          = 3000;
  localparam int RAND_START = 90;
  localparam int RST_CYC    = 71;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nes_debugger_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef NES_DEBUGGER_ARB_STATS_EN
  logic [15:0] conflict_count;
`endif

  nes_debugger_mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .WAIT_WIDTH(WW)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
`ifdef NES_DEBUGGER_ARB_STATS_EN
    ,
    .o_conflict_count(conflict_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-first, data valid the cycle after en.
  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] mem_q = 8'h00;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wea) ram[bus.mem_address] <= bus.mem_wr_data;
      mem_q <= ram[bus.mem_address];
    end
  end
  assign bus.mem_rd_data = mem_q;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  bit          nes_sched [0:N+63];
  bit          en_hist   [0:N+63];
  bit          rst_hist  [0:N+63];
  logic [25:0] exp_bus   [0:N+63];
  exp_t        dq[$];
  exp_t        nq[$];

  bit         have_req = 1'b0;
  int         cur_t = 0, cur_a = 0, cur_d = 0;
  logic [7:0] last_rd  = 8'h00;
  logic [7:0] last_nes = 8'h00;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, c, act, want);
    end
  endtask

  // Driver and reference model: decides acceptance and timing from the NES-enable schedule.
  initial begin
    logic        req, rw, nrw;
    logic [15:0] addr, naddr;
    logic [7:0]  data, ndata;
    int          p, a, i;

    for (int k = 0; k < 65536; k++) begin
      ram[k]     = 8'($urandom);
      ref_mem[k] = ram[k];
    end
    for (int k = 0; k < N + 64; k++) begin
      nes_sched[k] = 1'b0;
      exp_bus[k]   = '0;
      rst_hist[k]  = (k < 3) || (k == RST_CYC);
    end
    for (int k = 21; k <= 30; k++) nes_sched[k] = 1'b1;
    for (int k = 42; k <= 49; k++) nes_sched[k] = 1'b1;
    i = RAND_START;
    while (i < N - 80) begin
      i += $urandom_range(0, 5);
      for (int k = 0; k < int'($urandom_range(1, 12)) && i < N - 80; k++) begin
        nes_sched[i] = 1'b1;
        i++;
      end
    end
    for (int k = 0; k < N + 64; k++) en_hist[k] = nes_sched[k] && !rst_hist[k];

    bus.nes_en = 1'b0; bus.nes_rw = 1'b0; bus.nes_address = '0; bus.nes_wr_data = '0;
    bus.dbg_req = 1'b0; bus.dbg_rw = 1'b0; bus.dbg_address = '0; bus.dbg_wr_data = '0;

    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      rst = rst_hist[c];

      nrw   = 1'($urandom_range(0, 1));
      naddr = 16'h8000 | 16'($urandom_range(0, 32767));
      ndata = 8'($urandom);
      if (en_hist[c]) begin
        exp_bus[c] = {1'b1, ~nrw, naddr, ndata};
        if (nrw) nq.push_back('{c + 1, ref_mem[naddr]});
        else     ref_mem[naddr] = ndata;
      end
      bus.nes_en = en_hist[c]; bus.nes_rw = nrw; bus.nes_address = naddr; bus.nes_wr_data = ndata;

      req  = 1'b0;
      rw   = 1'($urandom_range(0, 1));
      addr = 16'($urandom_range(0, 7) * 4369);
      data = 8'($urandom);
      case (c)
        5:           begin req = 1'b1; rw = 1'b0; addr = 16'h1234; data = 8'hA5; end
        12, 70, 75:  begin req = 1'b1; rw = 1'b1; addr = 16'h1234; end
        20:          begin req = 1'b1; rw = 1'b0; addr = 16'h4321; data = 8'h3C; end
        40:          begin req = 1'b1; rw = 1'b1; addr = 16'h4321; end
        60:          begin req = 1'b1; rw = 1'b1; addr = 16'h0000; end
        62, 63, 64:  begin req = 1'b1; rw = 1'b0; addr = 16'h0000; data = 8'hFF; end
        default:     req = (c >= RAND_START) && (c < N - 80) && ($urandom_range(0, 3) == 0);
      endcase

      if (rst_hist[c] && have_req && cur_t < c && c <= cur_d) begin
        for (int x = c + 1; x <= cur_d; x++) exp_bus[x] = '0;
        cur_d = c;
        cur_a = c;
        dq.delete();
      end

      if (req && !rst_hist[c] && !(have_req && cur_t < c && c <= cur_d)) begin
        p = c + 1;
        while (en_hist[p]) p++;
        a = p + 1;
        while (en_hist[a]) a++;
        have_req   = 1'b1;
        cur_t      = c;
        cur_a      = a;
        cur_d      = a + 2;
        exp_bus[a] = {1'b1, ~rw, addr, data};
        if (rw) dq.push_back('{a + 2, ref_mem[addr]});
        else begin
          dq.push_back('{a + 2, last_rd});
          ref_mem[addr] = data;
        end
      end
      bus.dbg_req = req; bus.dbg_rw = rw; bus.dbg_address = addr; bus.dbg_wr_data = data;
    end
  end

  // Monitor: compares every cycle against the model state for that cycle.
  initial begin
    int blk_run;
    int cc;
    bit exp_done;
    blk_run = 0;
    cc      = 0;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      if (c > 0) begin
        check("dbg_ready", c, bus.dbg_ready, !(have_req && cur_t < c && c <= cur_d));
        while (dq.size() > 0 && dq[0].cyc < c) void'(dq.pop_front());
        exp_done = (dq.size() > 0) && (dq[0].cyc == c);
        check("dbg_done", c, bus.dbg_done, exp_done);
        if (exp_done) begin
          last_rd = dq[0].data;
          void'(dq.pop_front());
        end
        check("dbg_rd_data", c, bus.dbg_rd_data, last_rd);
        if (nq.size() > 0 && nq[0].cyc == c) begin
          last_nes = nq[0].data;
          void'(nq.pop_front());
        end
        check("nes_rd_data", c, bus.nes_rd_data, last_nes);
        check("dbg_starved", c, bus.dbg_starved, blk_run >= WMAX);
        check("mem_bus", c, {bus.mem_en, bus.mem_wea, bus.mem_address, bus.mem_wr_data}, exp_bus[c]);
`ifdef NES_DEBUGGER_ARB_STATS_EN
        check("conflict_count", c, conflict_count, cc);
`endif
      end
      if (rst_hist[c]) begin
        blk_run  = 0;
        cc       = 0;
        last_rd  = 8'h00;
        last_nes = 8'h00;
      end else begin
        if (have_req && cur_t < c && c <= cur_a && en_hist[c]) begin
          if (blk_run < WMAX) blk_run++;
          if (cc < 65535) cc++;
        end
        if (have_req && c == cur_d) blk_run = 0;
      end
    end
    check("scoreboard_drained", N, dq.size() + nq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
